daq_run_sequencer: RTL and testbench

Run-level controller sitting directly upstream of the per-acquisition DAQ control FSM. It issues one-cycle `start` pulses and waits for the `Once_end` pulse that marks each completed acquisition/readout. It counts completed acquisitions, inserts a programmable gap between them, supports graceful stop, and aborts on a watchdog timeout. Run commands and settings come from the USB command decoder.

---
 rtl/daq_pkg.sv | 29 ++
 rtl/daq_watchdog.sv | 66 ++++++
 rtl/daq_run_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_daq_run_sequencer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// -----------------------------------------------------------------------------
// daq_pkg
// Shared definitions for the DAQ run-level sequencer and its watchdog.
//   - Default widths for the acquisition counter, gap counter and watchdog.
//   - Minimum inter-acquisition gap. It guarantees the downstream per-acquisition
//     FSM has returned to Idle before the next start pulse.
//   - Run sequencer state encoding (3-bit).
// -----------------------------------------------------------------------------
package daq_pkg;

    // Default widths
    localparam int DAQ_CNT_W   = 16;   // acquisition target / done counter
    localparam int DAQ_GAP_W   = 16;   // inter-acquisition gap count
    localparam int DAQ_TMO_W   = 24;   // watchdog count (40 MHz cycles)

    // Shortest gap the sequencer will ever insert between Once_end and the next
    // start. Smaller programmed gaps (including 0) are raised to this value.
    localparam int DAQ_MIN_GAP = 2;

    // Run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_END = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4
    } run_state_e;

endpackage : daq_pkg

// File: rtl/daq_watchdog.sv
// -----------------------------------------------------------------------------
// daq_watchdog
// Loadable watchdog counter with clear, count enable and a terminal-count flag.
// The limit is captured by load_i and held until the next load, so the limit
// input may change freely in between. A limit of zero disables the watchdog.
// The count saturates at all-ones and never wraps.
//
// Ports
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (clears limit and count)
//   load_i     : capture limit_i as the new limit
//   limit_i    : watchdog limit in cycles (0 = disabled)
//   clear_i    : zero the count (has priority over enable_i)
//   enable_i   : advance the count by one this cycle
//   expired_o  : combinational; high in the cycle where the enabled count is
//                limit-1, i.e. the limit-th enabled cycle since the last clear
// -----------------------------------------------------------------------------
module daq_watchdog
    import daq_pkg::*;
#(
    parameter int TMO_W = DAQ_TMO_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [TMO_W-1:0] limit_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic             expired_o
);

    logic [TMO_W-1:0] limit_q, limit_d;
    logic [TMO_W-1:0] count_q, count_d;

    always_comb begin
        limit_d = limit_q;
        count_d = count_q;

        if (load_i) begin
            limit_d = limit_i;
        end

        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            limit_q <= '0;
            count_q <= '0;
        end else begin
            limit_q <= limit_d;
            count_q <= count_d;
        end
    end

    // The count starts at 0 in the first enabled cycle, so matching limit-1
    // flags the limit-th enabled cycle.
    assign expired_o = enable_i
                    && (limit_q != '0)
                    && (count_q == (limit_q - TMO_W'(1)));

endmodule : daq_watchdog

// File: rtl/daq_run_sequencer.sv
// -----------------------------------------------------------------------------
// daq_run_sequencer
// Run-level controller in front of the per-acquisition DAQ control FSM.
// A run is started by Run_start. The sequencer then repeats
//     ARM (start pulse) -> WAIT_END (wait for Once_end) -> GAP
// until one of these happens:
//     - the acquisition target is reached;
//     - a graceful stop is requested;
//     - the watchdog expires while waiting for Once_end.
// The run then passes through DONE (Run_done pulse) back to IDLE.
// Settings are captured when Run_start is accepted and stay fixed for the run.
//
// Ports
//   Clk            : 40 MHz system clock
//   reset_n        : synchronous active-low reset; abandons a run silently
//   Run_start      : pulse, begins a run (accepted in IDLE only)
//   Run_stop       : pulse, graceful stop request
//   Acq_target     : acquisitions per run, 0 = unlimited
//   Idle_gap       : cycles between Once_end and the next start (min MIN_GAP)
//   Timeout_cycles : watchdog limit while waiting for Once_end, 0 = disabled
//   Once_end       : pulse from DAQ control, acquisition+readout finished
//   start          : one-cycle pulse to DAQ control (high in ARM)
//   Daq_abort      : one-cycle pulse on watchdog timeout
//   Run_busy       : high from ARM through DONE inclusive
//   Run_done       : one-cycle pulse when a run ends, for any cause
//   Timeout_flag   : sticky timeout indicator, cleared by the next accepted run
//   Acq_done_cnt   : completed acquisitions, saturating at all-ones
// -----------------------------------------------------------------------------
module daq_run_sequencer
    import daq_pkg::*;
#(
    parameter int CNT_W   = DAQ_CNT_W,
    parameter int GAP_W   = DAQ_GAP_W,
    parameter int TMO_W   = DAQ_TMO_W,
    parameter int MIN_GAP = DAQ_MIN_GAP
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             Run_start,
    input  logic             Run_stop,
    input  logic [CNT_W-1:0] Acq_target,
    input  logic [GAP_W-1:0] Idle_gap,
    input  logic [TMO_W-1:0] Timeout_cycles,
    input  logic             Once_end,
    output logic             start,
    output logic             Daq_abort,
    output logic             Run_busy,
    output logic             Run_done,
    output logic             Timeout_flag,
    output logic [CNT_W-1:0] Acq_done_cnt
);

    // MIN_GAP must be at least 1: the gap length is compared against
    // gap_len_q - 1, which would wrap for a zero length.
    localparam logic [GAP_W-1:0] MIN_GAP_V = GAP_W'(MIN_GAP);

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    run_state_e       state_q,     state_d;
    logic [CNT_W-1:0] target_q,    target_d;    // latched acquisition target
    logic [GAP_W-1:0] gap_len_q,   gap_len_d;   // latched gap, already clamped
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;   // cycles spent in GAP so far
    logic             stop_pend_q, stop_pend_d; // graceful stop requested
    logic [CNT_W-1:0] cnt_q,       cnt_d;       // completed acquisitions
    logic             tmo_flag_q,  tmo_flag_d;  // sticky timeout flag
    logic             abort_q,     abort_d;     // registered abort pulse

    logic             run_accept;               // Run_start taken in IDLE
    logic             wd_expired;
    logic [CNT_W-1:0] cnt_inc;                  // saturating cnt_q + 1
    logic             stop_now;                 // stop pending or arriving now

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));
    assign stop_now = stop_pend_q | Run_stop;

    // -------------------------------------------------------------------------
    // Watchdog: limit captured at run accept, cleared in ARM and counting in
    // WAIT_END, so it measures the time spent waiting for each Once_end.
    // -------------------------------------------------------------------------
    daq_watchdog #(
        .TMO_W     (TMO_W)
    ) u_watchdog (
        .clk_i     (Clk),
        .rst_ni    (reset_n),
        .load_i    (run_accept),
        .limit_i   (Timeout_cycles),
        .clear_i   (state_q == ST_ARM),
        .enable_i  (state_q == ST_WAIT_END),
        .expired_o (wd_expired)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;
        tmo_flag_d  = tmo_flag_q;
        abort_d     = 1'b0;
        run_accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Run_stop and Once_end carry no meaning outside a run.
                if (Run_start) begin
                    run_accept  = 1'b1;
                    target_d    = Acq_target;
                    gap_len_d   = (Idle_gap < MIN_GAP_V) ? MIN_GAP_V : Idle_gap;
                    cnt_d       = '0;
                    tmo_flag_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_ARM;
                end
            end

            ST_ARM: begin
                if (Run_stop) begin
                    stop_pend_d = 1'b1;
                end
                state_d = ST_WAIT_END;
            end

            ST_WAIT_END: begin
                if (Run_stop) begin
                    stop_pend_d = 1'b1;
                end
                // Once_end is checked first: a completion in the same cycle
                // as the watchdog expiry is a success, not a timeout.
                if (Once_end) begin
                    cnt_d = cnt_inc;
                    // The target compare uses the saturated count, so a
                    // target of all-ones ends the run at saturation.
                    if (stop_now || ((target_q != '0) && (cnt_inc == target_q))) begin
                        state_d = ST_DONE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end else if (wd_expired) begin
                    abort_d    = 1'b1;
                    tmo_flag_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end

            ST_GAP: begin
                // Once_end here is a protocol error and is deliberately not
                // counted.
                if (Run_stop) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == (gap_len_q - GAP_W'(1))) begin
                    state_d = ST_ARM;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            tmo_flag_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
            tmo_flag_q  <= tmo_flag_d;
            abort_q     <= abort_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs are decoded from registered state only, so they are glitch-free.
    // The abort pulse coincides with the DONE cycle of a timed-out run.
    // -------------------------------------------------------------------------
    assign start        = (state_q == ST_ARM);
    assign Run_busy     = (state_q != ST_IDLE);
    assign Run_done     = (state_q == ST_DONE);
    assign Daq_abort    = abort_q;
    assign Timeout_flag = tmo_flag_q;
    assign Acq_done_cnt = cnt_q;

endmodule : daq_run_sequencer

// File: tb/tb_daq_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_daq_run_sequencer
// Directed bench for daq_run_sequencer. A small DAQ-control model answers
// every start with Once_end after resp_delay cycles. An event monitor records
// cycle numbers of start, Once_end, Run_done and Daq_abort. Each scenario task
// drives a run and compares the recorded timing with hand-computed values.
// -----------------------------------------------------------------------------
module tb_daq_run_sequencer;

    localparam int CNT_W = 16;
    localparam int GAP_W = 16;
    localparam int TMO_W = 24;

    logic             Clk            = 1'b0;
    logic             reset_n        = 1'b0;
    logic             Run_start      = 1'b0;
    logic             Run_stop       = 1'b0;
    logic [CNT_W-1:0] Acq_target     = '0;
    logic [GAP_W-1:0] Idle_gap       = '0;
    logic [TMO_W-1:0] Timeout_cycles = '0;
    logic             Once_end       = 1'b0;
    logic             start;
    logic             Daq_abort;
    logic             Run_busy;
    logic             Run_done;
    logic             Timeout_flag;
    logic [CNT_W-1:0] Acq_done_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // DAQ-control model configuration (written by the stimulus thread only)
    bit resp_en       = 1'b0;
    int resp_delay    = 50;
    int extra_end_cyc = -1;   // one-off extra Once_end at this cycle

    // Monitor state (written by the monitor only)
    int   pend_end_cyc = -1;
    int   n_start      = 0;
    int   n_end        = 0;
    int   n_done       = 0;
    int   n_abort      = 0;
    int   last_start   = -1;
    int   last_end     = -1;
    int   last_gap     = 0;
    int   last_done    = -1;
    int   last_abort   = -1;

    daq_run_sequencer #(
        .CNT_W          (CNT_W),
        .GAP_W          (GAP_W),
        .TMO_W          (TMO_W),
        .MIN_GAP        (2)
    ) dut (
        .Clk            (Clk),
        .reset_n        (reset_n),
        .Run_start      (Run_start),
        .Run_stop       (Run_stop),
        .Acq_target     (Acq_target),
        .Idle_gap       (Idle_gap),
        .Timeout_cycles (Timeout_cycles),
        .Once_end       (Once_end),
        .start          (start),
        .Daq_abort      (Daq_abort),
        .Run_busy       (Run_busy),
        .Run_done       (Run_done),
        .Timeout_flag   (Timeout_flag),
        .Acq_done_cnt   (Acq_done_cnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    logic oe_now;
    assign oe_now = (resp_en && (cyc == pend_end_cyc)) || (cyc == extra_end_cyc);

    // Monitor + DAQ model, on the falling edge. Once_end driven here is seen
    // by the DUT as belonging to cycle number cyc.
    always @(negedge Clk) begin
        Once_end <= oe_now;
        if (oe_now) begin
            n_end    <= n_end + 1;
            last_end <= cyc;
        end
        if (start === 1'b1) begin
            n_start      <= n_start + 1;
            last_start   <= cyc;
            last_gap     <= cyc - last_end;
            pend_end_cyc <= cyc + resp_delay;
        end
        if (Run_done === 1'b1) begin
            n_done    <= n_done + 1;
            last_done <= cyc;
        end
        if (Daq_abort === 1'b1) begin
            n_abort    <= n_abort + 1;
            last_abort <= cyc;
        end
    end

    // Safety net in case a wait is ever left unbounded
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic pulse_run_start();
        Run_start = 1'b1;
        step();
        Run_start = 1'b0;
    endtask

    task automatic wait_start(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_start >= n) break;
            step();
        end
        ok = (n_start >= n);
    endtask

    task automatic wait_end(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_end >= n) break;
            step();
        end
        ok = (n_end >= n);
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_done >= n) break;
            step();
        end
        ok = (n_done >= n);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        int b;
        reset_n        = 1'b0;
        Acq_target     = 16'd5;
        Idle_gap       = 16'd3;
        Timeout_cycles = 24'd7;
        step();
        step();
        checks++;
        if ({start, Daq_abort, Run_busy, Run_done, Timeout_flag} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {start, Daq_abort, Run_busy, Run_done, Timeout_flag});
        end
        checks++;
        if (Acq_done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", Acq_done_cnt);
        end
        reset_n = 1'b1;
        b = n_start;
        Run_stop = 1'b1;
        step();
        Run_stop = 1'b0;
        step();
        step();
        checks++;
        if (Run_busy !== 1'b0 || n_start != b) begin
            errors++;
            $display("FAIL idle_ignores_stop: busy %b starts %0d expected busy 0 starts 0",
                     Run_busy, n_start - b);
        end
        $display("test_reset done");
    endtask

    task automatic test_target_run();
        int  b_start, b_done, b_abort, t0, s1;
        bit  ok;
        Acq_target     = 16'd3;
        Idle_gap       = 16'd10;
        Timeout_cycles = 24'd0;
        resp_en        = 1'b1;
        resp_delay     = 50;
        b_start = n_start;
        b_done  = n_done;
        b_abort = n_abort;
        t0 = cyc;
        pulse_run_start();
        checks++;
        if (start !== 1'b1 || cyc != t0 + 1) begin
            errors++;
            $display("FAIL start_latency: start %b at +%0d expected 1 at +1", start, cyc - t0);
        end
        s1 = cyc;
        for (int k = 2; k <= 3; k++) begin
            wait_start(b_start + k, 200, ok);
            checks++;
            if (!ok || last_gap != 11) begin
                errors++;
                $display("FAIL target_gap%0d: ok %0d gap %0d expected ok 1 gap 11", k, ok, last_gap);
            end
        end
        wait_done(b_done + 1, 300, ok);
        checks++;
        if (!ok || Run_busy !== 1'b1 || last_done - s1 != 173) begin
            errors++;
            $display("FAIL target_done: ok %0d busy %b at +%0d expected ok 1 busy 1 at +173",
                     ok, Run_busy, last_done - s1);
        end
        checks++;
        if (Acq_done_cnt !== 16'd3) begin
            errors++;
            $display("FAIL target_cnt: got %0d expected 3", Acq_done_cnt);
        end
        step();
        checks++;
        if (Run_busy !== 1'b0 || Run_done !== 1'b0) begin
            errors++;
            $display("FAIL target_busy_fall: busy %b done %b expected 0 0", Run_busy, Run_done);
        end
        repeat (80) step();
        checks++;
        if (n_start - b_start != 3 || n_done - b_done != 1 || n_abort != b_abort) begin
            errors++;
            $display("FAIL target_counts: starts %0d dones %0d aborts %0d expected 3 1 0",
                     n_start - b_start, n_done - b_done, n_abort - b_abort);
        end
        $display("test_target_run done");
    endtask

    task automatic test_stop_run();
        int b_start, b_done, s1, s2;
        bit ok;
        Acq_target     = 16'd0;
        Idle_gap       = 16'd5;
        Timeout_cycles = 24'd0;
        resp_en        = 1'b1;
        resp_delay     = 50;
        b_start = n_start;
        b_done  = n_done;
        pulse_run_start();
        s1 = cyc;
        // Stray Once_end in the first gap must not be counted
        extra_end_cyc = s1 + 52;
        wait_start(b_start + 2, 200, ok);
        s2 = cyc;
        checks++;
        if (!ok || s2 - s1 != 56) begin
            errors++;
            $display("FAIL stop_second_start: ok %0d at +%0d expected ok 1 at +56", ok, s2 - s1);
        end
        repeat (21) step();
        Run_stop = 1'b1;
        step();
        Run_stop = 1'b0;
        wait_done(b_done + 1, 200, ok);
        checks++;
        if (!ok || last_done - s2 != 51) begin
            errors++;
            $display("FAIL stop_done_time: ok %0d at +%0d expected ok 1 at +51", ok, last_done - s2);
        end
        checks++;
        if (Acq_done_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stop_cnt: got %0d expected 2", Acq_done_cnt);
        end
        repeat (70) step();
        checks++;
        if (n_start - b_start != 2 || Run_busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_third_start: starts %0d busy %b expected 2 0",
                     n_start - b_start, Run_busy);
        end
        extra_end_cyc = -1;
        $display("test_stop_run done");
    endtask

    task automatic test_timeout();
        int b_done, b_abort, s1;
        bit ok;
        Acq_target     = 16'd0;
        Idle_gap       = 16'd2;
        Timeout_cycles = 24'd100;
        resp_en        = 1'b0;
        b_done  = n_done;
        b_abort = n_abort;
        pulse_run_start();
        s1 = cyc;
        // Changes after the run has started must have no effect
        Timeout_cycles = 24'd10;
        Acq_target     = 16'd1;
        wait_done(b_done + 1, 300, ok);
        checks++;
        if (!ok || n_abort - b_abort != 1 || last_abort - s1 != 101) begin
            errors++;
            $display("FAIL timeout_abort: ok %0d aborts %0d at +%0d expected ok 1 aborts 1 at +101",
                     ok, n_abort - b_abort, last_abort - s1);
        end
        checks++;
        if (last_done != last_abort || Timeout_flag !== 1'b1 || Acq_done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_state: done-abort %0d flag %b cnt %0d expected 0 1 0",
                     last_done - last_abort, Timeout_flag, Acq_done_cnt);
        end
        repeat (3) step();
        checks++;
        if (Timeout_flag !== 1'b1 || Run_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: flag %b busy %b expected 1 0", Timeout_flag, Run_busy);
        end
        // Next run clears the flag and completes normally
        Acq_target     = 16'd1;
        Timeout_cycles = 24'd100;
        resp_en        = 1'b1;
        resp_delay     = 5;
        b_done  = n_done;
        b_abort = n_abort;
        pulse_run_start();
        checks++;
        if (start !== 1'b1 || Timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag_clear: start %b flag %b expected 1 0", start, Timeout_flag);
        end
        wait_done(b_done + 1, 100, ok);
        checks++;
        if (!ok || Acq_done_cnt !== 16'd1 || n_abort != b_abort || Timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rerun: ok %0d cnt %0d aborts %0d flag %b expected 1 1 0 0",
                     ok, Acq_done_cnt, n_abort - b_abort, Timeout_flag);
        end
        repeat (5) step();
        $display("test_timeout done");
    endtask

    task automatic test_coincident();
        int b_done, b_abort, s1;
        bit ok;
        Acq_target     = 16'd1;
        Idle_gap       = 16'd2;
        Timeout_cycles = 24'd40;
        resp_en        = 1'b1;
        resp_delay     = 40;   // Once_end at WAIT_END cycle index 39
        b_done  = n_done;
        b_abort = n_abort;
        pulse_run_start();
        s1 = cyc;
        wait_done(b_done + 1, 100, ok);
        checks++;
        if (!ok || last_done - s1 != 41 || n_abort != b_abort) begin
            errors++;
            $display("FAIL coincident_done: ok %0d at +%0d aborts %0d expected 1 at +41 aborts 0",
                     ok, last_done - s1, n_abort - b_abort);
        end
        checks++;
        if (Acq_done_cnt !== 16'd1 || Timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL coincident_state: cnt %0d flag %b expected 1 0", Acq_done_cnt, Timeout_flag);
        end
        repeat (5) step();
        $display("test_coincident done");
    endtask

    task automatic test_min_gap_and_ignores();
        int b_start, b_done, b_end, s2, e2;
        bit ok;
        Acq_target     = 16'd0;
        Idle_gap       = 16'd0;
        Timeout_cycles = 24'd0;
        resp_en        = 1'b1;
        resp_delay     = 10;
        b_start = n_start;
        b_done  = n_done;
        b_end   = n_end;
        pulse_run_start();
        wait_start(b_start + 2, 100, ok);
        s2 = cyc;
        checks++;
        if (!ok || last_gap != 3) begin
            errors++;
            $display("FAIL min_gap: ok %0d end-to-start %0d expected ok 1 and 3", ok, last_gap);
        end
        repeat (3) step();
        pulse_run_start();   // in WAIT_END: must be ignored
        repeat (2) step();
        checks++;
        if (n_start - b_start != 2 || Acq_done_cnt !== 16'd1 || start !== 1'b0 || Run_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignores_start: starts %0d cnt %0d start %b busy %b expected 2 1 0 1",
                     n_start - b_start, Acq_done_cnt, start, Run_busy);
        end
        wait_end(b_end + 2, 100, ok);
        e2 = last_end;
        step();              // now in the first GAP cycle
        Run_stop = 1'b1;
        step();
        Run_stop = 1'b0;
        wait_done(b_done + 1, 50, ok);
        checks++;
        if (!ok || last_done != e2 + 2 || Acq_done_cnt !== 16'd2) begin
            errors++;
            $display("FAIL gap_stop: ok %0d done at E+%0d cnt %0d expected 1 E+2 2",
                     ok, last_done - e2, Acq_done_cnt);
        end
        repeat (6) step();
        checks++;
        if (n_start - b_start != 2 || Run_busy !== 1'b0 || s2 <= 0) begin
            errors++;
            $display("FAIL gap_stop_no_start: starts %0d busy %b expected 2 0", n_start - b_start, Run_busy);
        end
        $display("test_min_gap_and_ignores done");
    endtask

    task automatic test_reset_midrun();
        int b_start, b_done, b_abort;
        bit ok;
        Acq_target     = 16'd0;
        Idle_gap       = 16'd2;
        Timeout_cycles = 24'd0;
        resp_en        = 1'b1;
        resp_delay     = 10;
        b_start = n_start;
        b_done  = n_done;
        b_abort = n_abort;
        pulse_run_start();
        wait_start(b_start + 2, 100, ok);
        repeat (4) step();
        checks++;
        if (!ok || Acq_done_cnt !== 16'd1 || Run_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: ok %0d cnt %0d busy %b expected 1 1 1", ok, Acq_done_cnt, Run_busy);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if ({start, Daq_abort, Run_busy, Run_done, Timeout_flag} !== 5'b00000 || Acq_done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: flags %b cnt %0d expected 00000 0",
                     {start, Daq_abort, Run_busy, Run_done, Timeout_flag}, Acq_done_cnt);
        end
        repeat (15) step();  // stale Once_end from the model lands in IDLE
        checks++;
        if (n_done != b_done || n_abort != b_abort || Run_busy !== 1'b0 || Acq_done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrun_silent: dones %0d aborts %0d busy %b cnt %0d expected 0 0 0 0",
                     n_done - b_done, n_abort - b_abort, Run_busy, Acq_done_cnt);
        end
        Acq_target = 16'd2;
        b_start = n_start;
        pulse_run_start();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL midrun_restart: start %b expected 1", start);
        end
        wait_done(b_done + 1, 100, ok);
        checks++;
        if (!ok || Acq_done_cnt !== 16'd2 || n_start - b_start != 2) begin
            errors++;
            $display("FAIL midrun_rerun: ok %0d cnt %0d starts %0d expected 1 2 2",
                     ok, Acq_done_cnt, n_start - b_start);
        end
        repeat (5) step();
        $display("test_reset_midrun done");
    endtask

    initial begin
        test_reset();
        test_target_run();
        test_stop_run();
        test_timeout();
        test_coincident();
        test_min_gap_and_ignores();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_daq_run_sequencer
